day_counter_ctrl: RTL and testbench

- Sequencer and configurator for the day/time counter datapath.
- Generates the 1 Hz count-enable from the system clock.
- Runs a button-driven set-mode FSM that snapshots the live date/time into shadow registers, edits them field by field with calendar-correct wrap, then loads them back with a one-cycle strobe.
- Sits between the user-input debouncers and the day counter.

---
 rtl/daycnt_pkg.sv | 53 +++++
 rtl/tick_prescaler.sv | 28 ++
 rtl/day_counter_ctrl.sv | 169 ++++++++++++++++
 tb/tb_day_counter_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/daycnt_pkg.sv
// Shared widths, set-mode state encoding and calendar helper for the day/time counter.
package daycnt_pkg;

  localparam int unsigned SEC_W = 6;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned HR_W  = 5;
  localparam int unsigned DAY_W = 5;
  localparam int unsigned MON_W = 4;
  localparam int unsigned YR_W  = 7;

  typedef enum logic [2:0] {
    StRun,
    StYear,
    StMonth,
    StDay,
    StHour,
    StMin,
    StCommit
  } state_e;

  localparam logic [2:0] FieldNone   = 3'd0;
  localparam logic [2:0] FieldYear   = 3'd1;
  localparam logic [2:0] FieldMonth  = 3'd2;
  localparam logic [2:0] FieldDay    = 3'd3;
  localparam logic [2:0] FieldHour   = 3'd4;
  localparam logic [2:0] FieldMinute = 3'd5;

  // Years 0..99 map to 2000..2099, so divisibility by 4 is the whole leap rule.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] month,
                                                      input logic [YR_W-1:0]  year);
    logic [DAY_W-1:0] days;
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: days = 5'd30;
      4'd2:                    days = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default:                 days = 5'd31;
    endcase
    return days;
  endfunction

  function automatic logic [2:0] field_of(input state_e st);
    logic [2:0] f;
    case (st)
      StYear:  f = FieldYear;
      StMonth: f = FieldMonth;
      StDay:   f = FieldDay;
      StHour:  f = FieldHour;
      StMin:   f = FieldMinute;
      default: f = FieldNone;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider; sec_edge is high on the wrap cycle of a 0..TICK_DIV-1 count.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic sec_edge
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign sec_edge = (cnt_q == CntMax);

endmodule

// File: rtl/day_counter_ctrl.sv
// Tick generation and button-driven set-mode editor for the day/time counter.
module day_counter_ctrl
  import daycnt_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1000000,
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic [SEC_W-1:0] cur_second,
  input  logic [MIN_W-1:0] cur_minute,
  input  logic [HR_W-1:0]  cur_hour,
  input  logic [DAY_W-1:0] cur_day,
  input  logic [MON_W-1:0] cur_month,
  input  logic [YR_W-1:0]  cur_year,
  output logic             tick,
  output logic             load,
  output logic [SEC_W-1:0] set_second,
  output logic [MIN_W-1:0] set_minute,
  output logic [HR_W-1:0]  set_hour,
  output logic [DAY_W-1:0] set_day,
  output logic [MON_W-1:0] set_month,
  output logic [YR_W-1:0]  set_year,
  output logic             editing,
  output logic [2:0]       field
);

  localparam int unsigned ToW = $clog2(TIMEOUT_S + 1);
  localparam logic [ToW-1:0] ToLast = ToW'(TIMEOUT_S - 1);

  state_e           state_q, state_d;
  logic [ToW-1:0]   to_q, to_d;
  logic             tick_q, tick_d;
  logic             load_q, load_d;
  logic             editing_q, editing_d;
  logic [2:0]       field_q, field_d;
  logic [MIN_W-1:0] minute_q, minute_d;
  logic [HR_W-1:0]  hour_q, hour_d;
  logic [DAY_W-1:0] day_q, day_d;
  logic [MON_W-1:0] month_q, month_d;
  logic [YR_W-1:0]  year_q, year_d;
  logic [DAY_W-1:0] dim;
  logic             sec_edge;

  // Seconds are always loaded as zero, so the live value is deliberately ignored.
  logic unused_cur_second;
  assign unused_cur_second = ^cur_second;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk     (clk),
    .reset   (reset),
    .clr     (load_q),
    .sec_edge(sec_edge)
  );

  assign dim = days_in_month(month_q, year_q);

  always_comb begin
    state_d  = state_q;
    to_d     = to_q;
    load_d   = 1'b0;
    minute_d = minute_q;
    hour_d   = hour_q;
    day_d    = day_q;
    month_d  = month_q;
    year_d   = year_q;
    tick_d   = sec_edge & (state_q == StRun) & run & ~btn_mode;

    unique case (state_q)
      StRun: begin
        to_d = '0;
        if (btn_mode) begin
          minute_d = cur_minute;
          hour_d   = cur_hour;
          day_d    = cur_day;
          month_d  = cur_month;
          year_d   = cur_year;
          state_d  = StYear;
        end
      end
      StYear, StMonth, StDay, StHour, StMin: begin
        if (btn_mode) begin
          to_d = '0;
          unique case (state_q)
            StYear:  state_d = StMonth;
            StMonth: begin
              state_d = StDay;
              if (day_q > dim) day_d = dim;
            end
            StDay:   state_d = StHour;
            StHour:  state_d = StMin;
            default: begin
              state_d = StCommit;
              load_d  = 1'b1;
            end
          endcase
        end else if (btn_inc) begin
          to_d = '0;
          unique case (state_q)
            StYear:  year_d   = (year_q >= YR_W'(99))   ? '0          : year_q + YR_W'(1);
            StMonth: month_d  = (month_q >= MON_W'(12)) ? MON_W'(1)   : month_q + MON_W'(1);
            StDay:   day_d    = (day_q >= dim)          ? DAY_W'(1)   : day_q + DAY_W'(1);
            StHour:  hour_d   = (hour_q >= HR_W'(23))   ? '0          : hour_q + HR_W'(1);
            default: minute_d = (minute_q >= MIN_W'(59)) ? '0         : minute_q + MIN_W'(1);
          endcase
        end else if (sec_edge) begin
          if (to_q == ToLast) begin
            state_d = StRun;
            to_d    = '0;
          end else begin
            to_d = to_q + ToW'(1);
          end
        end
      end
      default: begin
        state_d = StRun;
        to_d    = '0;
      end
    endcase

    editing_d = (state_d != StRun);
    field_d   = field_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      to_q      <= '0;
      tick_q    <= 1'b0;
      load_q    <= 1'b0;
      editing_q <= 1'b0;
      field_q   <= FieldNone;
      minute_q  <= '0;
      hour_q    <= '0;
      day_q     <= DAY_W'(1);
      month_q   <= MON_W'(1);
      year_q    <= '0;
    end else begin
      state_q   <= state_d;
      to_q      <= to_d;
      tick_q    <= tick_d;
      load_q    <= load_d;
      editing_q <= editing_d;
      field_q   <= field_d;
      minute_q  <= minute_d;
      hour_q    <= hour_d;
      day_q     <= day_d;
      month_q   <= month_d;
      year_q    <= year_d;
    end
  end

  assign tick       = tick_q;
  assign load       = load_q;
  assign editing    = editing_q;
  assign field      = field_q;
  assign set_second = '0;
  assign set_minute = minute_q;
  assign set_hour   = hour_q;
  assign set_day    = day_q;
  assign set_month  = month_q;
  assign set_year   = year_q;

endmodule

// File: tb/tb_day_counter_ctrl.sv
// Self-checking bench for day_counter_ctrl with a calendar-arithmetic reference model.
module tb_day_counter_ctrl;

  localparam int unsigned TDiv = 4;
  localparam int unsigned TOut = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] cur_second = '0;
  logic [5:0] cur_minute = '0;
  logic [4:0] cur_hour = '0;
  logic [4:0] cur_day = 5'd1;
  logic [3:0] cur_month = 4'd1;
  logic [6:0] cur_year = '0;
  logic       tick, load, editing;
  logic [5:0] set_second, set_minute;
  logic [4:0] set_hour, set_day;
  logic [3:0] set_month;
  logic [6:0] set_year;
  logic [2:0] field;

  int n_checks = 0;
  int n_fail = 0;

  day_counter_ctrl #(
    .TICK_DIV (TDiv),
    .TIMEOUT_S(TOut)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .cur_second(cur_second),
    .cur_minute(cur_minute),
    .cur_hour  (cur_hour),
    .cur_day   (cur_day),
    .cur_month (cur_month),
    .cur_year  (cur_year),
    .tick      (tick),
    .load      (load),
    .set_second(set_second),
    .set_minute(set_minute),
    .set_hour  (set_hour),
    .set_day   (set_day),
    .set_month (set_month),
    .set_year  (set_year),
    .editing   (editing),
    .field     (field)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int dim_ref(input int m, input int y);
    int days [12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    return days[m-1] + ((m == 2 && (y % 4) == 0) ? 1 : 0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    step();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick: got %0d want 0", tick); end
    n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %0d want 0", load); end
    n_checks++; if (editing !== 1'b0) begin n_fail++; $display("FAIL reset_editing: got %0d want 0", editing); end
    n_checks++; if (field !== 3'd0) begin n_fail++; $display("FAIL reset_field: got %0d want 0", field); end
    n_checks++; if (set_second !== 6'd0) begin n_fail++; $display("FAIL reset_sec: got %0d want 0", set_second); end
    n_checks++; if (set_minute !== 6'd0) begin n_fail++; $display("FAIL reset_min: got %0d want 0", set_minute); end
    n_checks++; if (set_hour !== 5'd0) begin n_fail++; $display("FAIL reset_hour: got %0d want 0", set_hour); end
    n_checks++; if (set_day !== 5'd1) begin n_fail++; $display("FAIL reset_day: got %0d want 1", set_day); end
    n_checks++; if (set_month !== 4'd1) begin n_fail++; $display("FAIL reset_month: got %0d want 1", set_month); end
    n_checks++; if (set_year !== 7'd0) begin n_fail++; $display("FAIL reset_year: got %0d want 0", set_year); end
  endtask

  // First tick appears TDiv edges after reset release, then every TDiv cycles.
  task automatic test_tick();
    reset = 1'b0;
    run = 1'b1;
    for (int s = 1; s <= 4 * TDiv; s++) begin
      cur_second = 6'($urandom_range(0, 3));
      step();
      n_checks++;
      if (tick !== ((s % TDiv) == 0)) begin
        n_fail++; $display("FAIL tick_period s=%0d: got %0d want %0d", s, tick, (s % TDiv) == 0);
      end
      n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL tick_no_load s=%0d: got %0d want 0", s, load); end
    end
  endtask

  // Enter set mode exactly on a second edge: that tick must be swallowed.
  task automatic test_suppress();
    do_reset();
    repeat (TDiv - 1) step();
    press(1'b1, 1'b0);
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL suppress_tick: got %0d want 0", tick); end
    n_checks++; if (editing !== 1'b1) begin n_fail++; $display("FAIL suppress_edit: got %0d want 1", editing); end
    n_checks++; if (field !== 3'd1) begin n_fail++; $display("FAIL suppress_field: got %0d want 1", field); end
    do_reset();
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic test_edit(input int y, input int mo, input int d, input int h, input int mi,
                           input int ny, input int nmo, input int nd, input int nh, input int nmi);
    int ye, moe, dd, de, he, mie;
    int counts [5];
    counts = '{ny, nmo, nd, nh, nmi};
    ye  = (y + ny) % 100;
    moe = ((mo - 1 + nmo) % 12) + 1;
    dd  = (d > dim_ref(moe, ye)) ? dim_ref(moe, ye) : d;
    de  = ((dd - 1 + nd) % dim_ref(moe, ye)) + 1;
    he  = (h + nh) % 24;
    mie = (mi + nmi) % 60;
    cur_year = 7'(y); cur_month = 4'(mo); cur_day = 5'(d); cur_hour = 5'(h);
    cur_minute = 6'(mi); cur_second = 6'($urandom_range(0, 59));
    gap();
    press(1'b1, 1'b0);
    n_checks++; if (set_year !== 7'(y)) begin n_fail++; $display("FAIL edit_capture_year: got %0d want %0d", set_year, y); end
    for (int f = 0; f < 5; f++) begin
      n_checks++;
      if (field !== 3'(f + 1)) begin n_fail++; $display("FAIL edit_field: got %0d want %0d", field, f + 1); end
      if (f == 2) begin
        n_checks++; if (set_day !== 5'(dd)) begin n_fail++; $display("FAIL edit_clamp: got %0d want %0d", set_day, dd); end
      end
      for (int k = 0; k < counts[f]; k++) begin
        gap();
        press(1'b0, 1'b1);
      end
      gap();
      n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL edit_early_load: got %0d want 0", load); end
      press(1'b1, 1'b0);
    end
    n_checks++; if (load !== 1'b1) begin n_fail++; $display("FAIL commit_load: got %0d want 1", load); end
    n_checks++; if (field !== 3'd0) begin n_fail++; $display("FAIL commit_field: got %0d want 0", field); end
    n_checks++; if (set_year !== 7'(ye)) begin n_fail++; $display("FAIL commit_year: got %0d want %0d", set_year, ye); end
    n_checks++; if (set_month !== 4'(moe)) begin n_fail++; $display("FAIL commit_month: got %0d want %0d", set_month, moe); end
    n_checks++; if (set_day !== 5'(de)) begin n_fail++; $display("FAIL commit_day: got %0d want %0d", set_day, de); end
    n_checks++; if (set_hour !== 5'(he)) begin n_fail++; $display("FAIL commit_hour: got %0d want %0d", set_hour, he); end
    n_checks++; if (set_minute !== 6'(mie)) begin n_fail++; $display("FAIL commit_min: got %0d want %0d", set_minute, mie); end
    n_checks++; if (set_second !== 6'd0) begin n_fail++; $display("FAIL commit_sec: got %0d want 0", set_second); end
    step();
    n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL commit_load_drop: got %0d want 0", load); end
    n_checks++; if (editing !== 1'b0) begin n_fail++; $display("FAIL commit_edit_drop: got %0d want 0", editing); end
  endtask

  task automatic test_clamp();
    for (int leap = 0; leap < 2; leap++) begin
      do_reset();
      cur_year = (leap == 1) ? 7'd24 : 7'd23; cur_month = 4'd2; cur_day = 5'd31;
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      n_checks++;
      if (set_day !== ((leap == 1) ? 5'd29 : 5'd28)) begin
        n_fail++; $display("FAIL clamp_feb leap=%0d: got %0d want %0d", leap, set_day, 28 + leap);
      end
      if (leap == 1) begin
        press(1'b0, 1'b1);
        n_checks++; if (set_day !== 5'd1) begin n_fail++; $display("FAIL clamp_wrap: got %0d want 1", set_day); end
      end
    end
    do_reset();
  endtask

  // Three idle seconds in set mode abandon the edit without a load.
  task automatic test_timeout();
    int k;
    logic saw_load;
    do_reset();
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    step();
    press(1'b1, 1'b0);
    n_checks++; if (field !== 3'd4) begin n_fail++; $display("FAIL timeout_field: got %0d want 4", field); end
    // Last press was the 5th edge after reset; remaining edges come on cycles 8, 12, 16.
    k = 0;
    saw_load = 1'b0;
    while (editing === 1'b1 && k < 4 * TDiv) begin
      step();
      k++;
      if (load === 1'b1) saw_load = 1'b1;
      if (editing === 1'b1 && tick !== 1'b0) begin
        n_checks++; n_fail++; $display("FAIL timeout_tick_in_edit: got %0d want 0", tick);
      end
    end
    n_checks++; if (k != 3 * TDiv - 1) begin n_fail++; $display("FAIL timeout_delay: got %0d want %0d", k, 3 * TDiv - 1); end
    n_checks++; if (saw_load !== 1'b0) begin n_fail++; $display("FAIL timeout_load: got %0d want 0", saw_load); end
    n_checks++; if (field !== 3'd0) begin n_fail++; $display("FAIL timeout_field0: got %0d want 0", field); end
    for (int s = 1; s <= TDiv; s++) begin
      step();
      n_checks++;
      if (tick !== (s == TDiv)) begin n_fail++; $display("FAIL timeout_resume s=%0d: got %0d want %0d", s, tick, s == TDiv); end
    end
  endtask

  task automatic test_collision_and_reset();
    do_reset();
    cur_year = 7'd21; cur_month = 4'd5; cur_day = 5'd10; cur_hour = 5'd8; cur_minute = 6'd30;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    n_checks++; if (field !== 3'd3) begin n_fail++; $display("FAIL collide_field: got %0d want 3", field); end
    n_checks++; if (set_month !== 4'd5) begin n_fail++; $display("FAIL collide_month: got %0d want 5", set_month); end
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    n_checks++; if (field !== 3'd5) begin n_fail++; $display("FAIL midreset_pre: got %0d want 5", field); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (editing !== 1'b0) begin n_fail++; $display("FAIL midreset_edit: got %0d want 0", editing); end
    n_checks++; if (field !== 3'd0) begin n_fail++; $display("FAIL midreset_field: got %0d want 0", field); end
    n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL midreset_load: got %0d want 0", load); end
    n_checks++; if (set_month !== 4'd1) begin n_fail++; $display("FAIL midreset_month: got %0d want 1", set_month); end
    step();
    n_checks++; if (load !== 1'b0) begin n_fail++; $display("FAIL midreset_load2: got %0d want 0", load); end
  endtask

  task automatic test_random_edits();
    for (int n = 0; n < 8; n++) begin
      int y, mo, d;
      y  = $urandom_range(0, 99);
      mo = $urandom_range(1, 12);
      d  = $urandom_range(1, 31);
      test_edit(y, mo, d, $urandom_range(0, 23), $urandom_range(0, 59),
                $urandom_range(0, 6), $urandom_range(0, 14), $urandom_range(0, 6),
                $urandom_range(0, 6), $urandom_range(0, 6));
    end
  endtask

  initial begin
    test_reset();
    test_tick();
    test_suppress();
    test_edit(23, 2, 29, 10, 15, 1, 0, 0, 1, 1);
    test_edit(99, 12, 31, 23, 59, 1, 1, 0, 1, 1);
    test_clamp();
    test_timeout();
    test_collision_and_reset();
    test_random_edits();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
